tx_msg_fifo: RTL

//  Single-clock byte FIFO and launch FSM in the REF_CLK domain. Sits between SYS_CTRL
//  (producer of response bytes) and the TX-side data synchronizer that feeds UART TX.

---
 rtl/tx_msg_fifo_pkg.sv | 15 +
 rtl/tx_msg_fifo_if.sv | 32 +++
 rtl/tx_fifo_mem.sv | 25 ++
 rtl/tx_msg_fifo.sv | 139 +++++++++++++
 4 files changed

// File: rtl/tx_msg_fifo_pkg.sv
// Shared definitions for the TX message FIFO: default sizing and launch FSM state encodings.
package tx_msg_fifo_pkg;

  localparam int unsigned TxfWidth      = 8;
  localparam int unsigned TxfDepth      = 8;
  localparam int unsigned TxfTimeoutCyc = 64;

  typedef enum logic [1:0] {
    TxfIdle     = 2'd0,
    TxfLaunch   = 2'd1,
    TxfWaitBusy = 2'd2,
    TxfWaitDone = 2'd3
  } txf_state_e;

endpackage

// File: rtl/tx_msg_fifo_if.sv
// Push-side and UART-launch-side signals of the TX message FIFO.
interface tx_msg_fifo_if
  import tx_msg_fifo_pkg::*;
#(
  parameter int unsigned Width = TxfWidth,
  parameter int unsigned Depth = TxfDepth
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] wr_data;
  logic             wr_vld;
  logic             full;
  logic             empty;
  logic [PtrW:0]    count;
  logic             overflow;
  logic             tx_busy;
  logic [Width-1:0] tx_data;
  logic             tx_vld;

  // Producer / UART-side view
  modport master (
    output wr_data, wr_vld, tx_busy,
    input  full, empty, count, overflow, tx_data, tx_vld
  );

  // FIFO view
  modport slave (
    input  wr_data, wr_vld, tx_busy,
    output full, empty, count, overflow, tx_data, tx_vld
  );

endinterface

// File: rtl/tx_fifo_mem.sv
// Depth x Width byte store: synchronous write, combinational read, no reset on the array.
module tx_fifo_mem #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PtrW-1:0]  waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [PtrW-1:0]  raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tx_msg_fifo.sv
// Byte FIFO plus launch FSM pacing UART TX by its synchronised busy flag.
// Optional WAIT_BUSY re-launch timeout built only when TXF_TIMEOUT_EN is defined.
module tx_msg_fifo
  import tx_msg_fifo_pkg::*;
#(
  parameter int unsigned Width      = TxfWidth,
  parameter int unsigned Depth      = TxfDepth,
  parameter int unsigned TimeoutCyc = TxfTimeoutCyc
) (
  input logic          clk_i,
  input logic          rst_ni,
  tx_msg_fifo_if.slave bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(Depth);
  localparam logic [PtrW:0]   CntOne   = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

  logic [PtrW-1:0] wp_q, rp_q;
  logic [PtrW:0]   count_q, count_d;
  logic            full_q, empty_q, overflow_q;
  logic            push, pop;
  logic [Width-1:0] rdata;
  txf_state_e      state_q, state_d;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign push = bus.wr_vld & ~full_q;
  assign pop  = (state_q == TxfWaitBusy) & bus.tx_busy;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + PtrOne;
      if (pop)  rp_q <= rp_q + PtrOne;
      count_q <= count_d;
      full_q  <= (count_d == DepthCnt);
      empty_q <= (count_d == '0);
      if (bus.wr_vld && full_q) overflow_q <= 1'b1;
    end
  end

  tx_fifo_mem #(
    .Width (Width),
    .Depth (Depth)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wp_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rp_q),
    .rdata_o (rdata)
  );

`ifdef TXF_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCyc + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCyc - 1);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TimeoutCyc;
`endif

  always_comb begin
    state_d = state_q;
`ifdef TXF_TIMEOUT_EN
    tmo_d = tmo_q;
`endif
    unique case (state_q)
      TxfIdle: begin
        if (!empty_q && !bus.tx_busy) state_d = TxfLaunch;
      end
      TxfLaunch: begin
        state_d = TxfWaitBusy;
`ifdef TXF_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      TxfWaitBusy: begin
        if (bus.tx_busy) begin
          state_d = TxfWaitDone;
        end
`ifdef TXF_TIMEOUT_EN
        // No busy seen: re-issue the same head byte, nothing is popped.
        else if (tmo_q == TmoLast) begin
          state_d = TxfLaunch;
        end else begin
          tmo_d = tmo_q + TmoOne;
        end
`endif
      end
      TxfWaitDone: begin
        if (!bus.tx_busy) state_d = TxfIdle;
      end
      default: state_d = TxfIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TxfIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.tx_vld   = (state_q == TxfLaunch);
  assign bus.tx_data  = rdata;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule
